fu_arbiter: RTL and testbench
=============================

FU_ARBITER -- requirements
Module: fu_arbiter

Interface
REQ-001 SHALL provide port clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL provide port rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL provide ports reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-004 SHALL provide ports reqN_ready  output  1  requester N operation accepted this cycle.
REQ-005 SHALL provide ports reqN_fs  input  4  requester N function-select code.
REQ-006 SHALL provide ports reqN_a, reqN_b  input  16  requester N operands A, B.
REQ-007 SHALL provide port fu_fs  output  4  select code driven to the shared function unit.
REQ-008 SHALL provide ports fu_a, fu_b  output  16  operands driven to the function unit.
REQ-009 SHALL provide port fu_result  input  16  function-unit result.
REQ-010 SHALL provide port fu_status  input  4  function-unit {V,C,N,Z}.
REQ-011 SHALL provide port rsp_valid  output  1  response available.
REQ-012 SHALL provide port rsp_ready  input  1  consumer accepts response.
REQ-013 SHALL provide port rsp_id  output  1  index of requester that issued the operation.
REQ-014 SHALL provide port rsp_result  output  16  registered result.
REQ-015 SHALL provide port rsp_status  output  4  registered {V,C,N,Z}.
REQ-016 SHALL provide port rsp_err  output  1  operation carried an illegal select code.

Function
REQ-017 SHALL implement FSM states IDLE, EXEC, RESP; reset state IDLE.
REQ-018 SHALL, in IDLE, grant one requester when any reqN_valid=1: if only one is valid, grant it; if both, grant the one not granted last (round-robin).
REQ-019 SHALL assert reqN_ready for exactly the granted requester, for one cycle, only in IDLE; never both.
REQ-020 SHALL, on grant, latch reqN_fs, reqN_a, reqN_b and requester index into internal op registers.
REQ-021 SHALL treat fs 0001..1101 as legal; fs 0000, 1110, 1111 as illegal.
REQ-022 SHALL, on a legal grant, go IDLE->EXEC; on an illegal grant, go IDLE->RESP directly with rsp_err=1, rsp_result=0, rsp_status=0.
REQ-023 SHALL, in EXEC (exactly one cycle), drive fu_fs/fu_a/fu_b from op registers, capture fu_result and fu_status into rsp registers at cycle end, set rsp_err=0, then go RESP.
REQ-024 SHALL drive fu_fs=0000, fu_a=0, fu_b=0 in every state except EXEC, so no FU tri-state driver is enabled.
REQ-025 SHALL hold rsp_valid=1 in RESP with rsp_id/result/status/err stable until rsp_ready=1; on that cycle return to IDLE.
REQ-026 SHALL update the round-robin pointer to the granted index at grant time.
REQ-027 SHALL yield legal-op latency of 2 cycles: reqN_ready at cycle T -> rsp_valid at T+2; illegal-op latency 1 cycle.
REQ-028 SHALL sustain at most one operation in flight; peak throughput one op per 3 cycles with rsp_ready tied high.
REQ-029 SHALL ignore reqN_valid changes outside IDLE; pending requests wait with reqN_ready=0.
REQ-030 SHALL pass fu_result/fu_status through unmodified; no arithmetic in this block.

Reset
REQ-031 SHALL, on rst_n=0 at any time including mid-EXEC or mid-RESP, immediately force state IDLE, rsp_valid=0, reqN_ready=0, rsp_id=0, rsp_result=0, rsp_status=0, rsp_err=0, fu_fs=0000, fu_a=0, fu_b=0, round-robin pointer=1 (requester 0 wins first tie); in-flight operation discarded.

Verification
REQ-032 SHALL cover: req0 fs=0001 A=0x0003 B=0x0004, FU model returns 0x0007 status 0000 -> req0_ready at T, rsp_valid at T+2, rsp_id=0, rsp_result=0x0007, rsp_err=0.
REQ-033 SHALL cover: both requesters valid continuously after reset, rsp_ready=1 -> grants 0,1,0,1 in order, one grant every 3 cycles.
REQ-034 SHALL cover: req1 fs=1111 -> req1_ready, rsp_valid next cycle, rsp_err=1, rsp_result=0x0000, rsp_status=0000, fu_fs stays 0000 throughout.
REQ-035 SHALL cover: rsp_ready held 0 for 5 cycles in RESP with req0 valid -> rsp outputs stable, req0_ready=0 until cycle after rsp_ready=1.
REQ-036 SHALL cover: rst_n pulsed low during EXEC -> all outputs zero asynchronously, no rsp_valid after release, next tie grants requester 0.

Source files
------------

// File: rtl/fu_arbiter.sv
// fu_arbiter: two-requester round-robin front end for a shared function unit.
// One operation in flight at a time. A granted operation with a legal select
// code spends one cycle driving the function unit (EXEC), then its captured
// result is held in RESP until the consumer accepts it. An illegal select code
// skips the function unit and goes straight to RESP with an error response.
// The function-unit bus is held at zero outside EXEC so that no FU driver is
// enabled unintentionally.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request; grants one requester per visit
// EXEC  | op registers drive the FU; result/status captured at cycle end
// RESP  | response held on rsp_* until rsp_ready

module fu_arbiter (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_fs,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_fs,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,

    output logic [3:0]  fu_fs,
    output logic [15:0] fu_a,
    output logic [15:0] fu_b,
    input  logic [15:0] fu_result,
    input  logic [3:0]  fu_status,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_result,
    output logic [3:0]  rsp_status,
    output logic        rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Index of the requester granted most recently; the other one wins a tie.
    logic        rr_ptr;

    logic [3:0]  op_fs;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        op_id;

    logic        any_req;
    logic        gnt_fire;
    logic        gnt_id;
    logic [3:0]  gnt_fs;
    logic [15:0] gnt_a;
    logic [15:0] gnt_b;
    logic        gnt_legal;

    // Select codes 0001..1101 map to FU functions; 0000, 1110, 1111 do not.
    function automatic logic fs_is_legal(input logic [3:0] fs);
        return (fs != 4'b0000) && (fs <= 4'b1101);
    endfunction

    // Grant selection: single requester wins outright, a tie goes to the
    // requester that was not granted last.
    always_comb begin
        any_req = req0_valid | req1_valid;
        gnt_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt_id = ~rr_ptr;
        end else if (req1_valid) begin
            gnt_id = 1'b1;
        end
        gnt_fire  = (state == IDLE) && any_req;
        gnt_fs    = gnt_id ? req1_fs : req0_fs;
        gnt_a     = gnt_id ? req1_a  : req0_a;
        gnt_b     = gnt_id ? req1_b  : req0_b;
        gnt_legal = fs_is_legal(gnt_fs);
    end

    // Handshake outputs. Gated by rst_n so ready is low for the whole time
    // reset is held, even though the state register already reads IDLE.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (rst_n && gnt_fire) begin
            req0_ready = ~gnt_id;
            req1_ready =  gnt_id;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (gnt_fire) begin
                    state_nxt = gnt_legal ? EXEC : RESP;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FU bus is driven only while executing; zero everywhere else.
    always_comb begin
        fu_fs = 4'b0000;
        fu_a  = 16'h0000;
        fu_b  = 16'h0000;
        if (state == EXEC) begin
            fu_fs = op_fs;
            fu_a  = op_a;
            fu_b  = op_b;
        end
    end

    // Response valid is a straight decode of the RESP state.
    always_comb begin
        rsp_valid = (state == RESP);
    end

    // State register and round-robin pointer; pointer starts at 1 so that
    // requester 0 wins the first tie after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= 1'b1;
        end else begin
            state <= state_nxt;
            if (gnt_fire) begin
                rr_ptr <= gnt_id;
            end
        end
    end

    // Op registers capture the granted request at grant time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_fs <= 4'b0000;
            op_a  <= 16'h0000;
            op_b  <= 16'h0000;
            op_id <= 1'b0;
        end else if (gnt_fire) begin
            op_fs <= gnt_fs;
            op_a  <= gnt_a;
            op_b  <= gnt_b;
            op_id <= gnt_id;
        end
    end

    // Response registers: loaded with an error response on an illegal grant,
    // or with the FU outputs at the end of EXEC; untouched while in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id     <= 1'b0;
            rsp_result <= 16'h0000;
            rsp_status <= 4'b0000;
            rsp_err    <= 1'b0;
        end else if (gnt_fire && !gnt_legal) begin
            rsp_id     <= gnt_id;
            rsp_result <= 16'h0000;
            rsp_status <= 4'b0000;
            rsp_err    <= 1'b1;
        end else if (state == EXEC) begin
            rsp_id     <= op_id;
            rsp_result <= fu_result;
            rsp_status <= fu_status;
            rsp_err    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fu_arbiter.sv
// Directed bench for fu_arbiter with a small behavioural function unit.
module tb_fu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid;
    logic        req0_ready;
    logic [3:0]  req0_fs;
    logic [15:0] req0_a;
    logic [15:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [3:0]  req1_fs;
    logic [15:0] req1_a;
    logic [15:0] req1_b;
    logic [3:0]  fu_fs;
    logic [15:0] fu_a;
    logic [15:0] fu_b;
    logic [15:0] fu_result;
    logic [3:0]  fu_status;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [15:0] rsp_result;
    logic [3:0]  rsp_status;
    logic        rsp_err;

    int tests;
    int fails;

    fu_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_fs    (req0_fs),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_fs    (req1_fs),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .fu_fs      (fu_fs),
        .fu_a       (fu_a),
        .fu_b       (fu_b),
        .fu_result  (fu_result),
        .fu_status  (fu_status),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_status (rsp_status),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Function unit stand-in: 0001 add, 0010 subtract, anything else xor.
    logic [15:0] fu_r;
    always_comb begin
        case (fu_fs)
            4'b0001: fu_r = fu_a + fu_b;
            4'b0010: fu_r = fu_a - fu_b;
            default: fu_r = fu_a ^ fu_b;
        endcase
        fu_result = fu_r;
        fu_status = {2'b00, fu_r[15], (fu_r == 16'h0000)};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " rsp_valid"},  32'(rsp_valid),  32'h0);
        chk({tag, " req0_ready"}, 32'(req0_ready), 32'h0);
        chk({tag, " req1_ready"}, 32'(req1_ready), 32'h0);
        chk({tag, " rsp_id"},     32'(rsp_id),     32'h0);
        chk({tag, " rsp_result"}, 32'(rsp_result), 32'h0);
        chk({tag, " rsp_status"}, 32'(rsp_status), 32'h0);
        chk({tag, " rsp_err"},    32'(rsp_err),    32'h0);
        chk({tag, " fu_fs"},      32'(fu_fs),      32'h0);
        chk({tag, " fu_a"},       32'(fu_a),       32'h0);
        chk({tag, " fu_b"},       32'(fu_b),       32'h0);
    endtask

    initial begin
        logic e0;
        logic e1;
        tests      = 0;
        fails      = 0;
        rst_n      = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_fs    = 4'b0001;
        req0_a     = 16'h0000;
        req0_b     = 16'h0000;
        req1_fs    = 4'b0001;
        req1_a     = 16'h0000;
        req1_b     = 16'h0000;
        rsp_ready  = 1'b0;

        // Reset: everything quiet even with both requests raised.
        tick();
        tick();
        chk_all_zero("reset");
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n      = 1'b1;
        tick();

        // Legal op from req0: 3 + 4 = 7, latency 2.
        req0_valid = 1'b1;
        req0_fs    = 4'b0001;
        req0_a     = 16'h0003;
        req0_b     = 16'h0004;
        #1;
        chk("add T req0_ready", 32'(req0_ready), 32'h1);
        chk("add T req1_ready", 32'(req1_ready), 32'h0);
        chk("add T fu_fs", 32'(fu_fs), 32'h0);
        tick();
        req0_valid = 1'b0;
        #1;
        chk("add T+1 rsp_valid", 32'(rsp_valid), 32'h0);
        chk("add T+1 req0_ready", 32'(req0_ready), 32'h0);
        chk("add T+1 fu_fs", 32'(fu_fs), 32'h1);
        chk("add T+1 fu_a", 32'(fu_a), 32'h3);
        chk("add T+1 fu_b", 32'(fu_b), 32'h4);
        tick();
        chk("add T+2 rsp_valid", 32'(rsp_valid), 32'h1);
        chk("add rsp_id", 32'(rsp_id), 32'h0);
        chk("add rsp_result", 32'(rsp_result), 32'h0007);
        chk("add rsp_status", 32'(rsp_status), 32'h0);
        chk("add rsp_err", 32'(rsp_err), 32'h0);
        chk("add T+2 fu_fs", 32'(fu_fs), 32'h0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("add back idle rsp_valid", 32'(rsp_valid), 32'h0);

        // Illegal op from req1: error response one cycle after grant.
        req1_valid = 1'b1;
        req1_fs    = 4'b1111;
        req1_a     = 16'h1234;
        req1_b     = 16'h5678;
        #1;
        chk("ill T req1_ready", 32'(req1_ready), 32'h1);
        chk("ill T req0_ready", 32'(req0_ready), 32'h0);
        chk("ill T fu_fs", 32'(fu_fs), 32'h0);
        tick();
        req1_valid = 1'b0;
        #1;
        chk("ill T+1 rsp_valid", 32'(rsp_valid), 32'h1);
        chk("ill rsp_err", 32'(rsp_err), 32'h1);
        chk("ill rsp_id", 32'(rsp_id), 32'h1);
        chk("ill rsp_result", 32'(rsp_result), 32'h0);
        chk("ill rsp_status", 32'(rsp_status), 32'h0);
        chk("ill T+1 fu_fs", 32'(fu_fs), 32'h0);
        chk("ill T+1 fu_a", 32'(fu_a), 32'h0);
        rsp_ready = 1'b1;
        tick();
        chk("ill back idle rsp_valid", 32'(rsp_valid), 32'h0);
        chk("ill back idle fu_fs", 32'(fu_fs), 32'h0);

        // Fresh reset, then both requesters valid continuously: 0,1,0,1.
        rst_n = 1'b0;
        tick();
        rst_n      = 1'b1;
        req0_valid = 1'b1;
        req0_fs    = 4'b0010;
        req0_a     = 16'h0010;
        req0_b     = 16'h0001;
        req1_valid = 1'b1;
        req1_fs    = 4'b0001;
        req1_a     = 16'hFFFF;
        req1_b     = 16'h0001;
        rsp_ready  = 1'b1;
        #1;
        for (int c = 0; c < 12; c++) begin
            e0 = ((c % 6) == 0);
            e1 = ((c % 6) == 3);
            chk($sformatf("rr c%0d req0_ready", c), 32'(req0_ready), 32'(e0));
            chk($sformatf("rr c%0d req1_ready", c), 32'(req1_ready), 32'(e1));
            if ((c % 3) == 1) begin
                chk($sformatf("rr c%0d fu_fs", c), 32'(fu_fs),
                    ((c % 6) == 1) ? 32'h2 : 32'h1);
            end
            if ((c % 3) == 2) begin
                chk($sformatf("rr c%0d rsp_valid", c), 32'(rsp_valid), 32'h1);
                if ((c % 6) == 2) begin
                    chk($sformatf("rr c%0d rsp_id", c), 32'(rsp_id), 32'h0);
                    chk($sformatf("rr c%0d rsp_result", c), 32'(rsp_result), 32'h000F);
                    chk($sformatf("rr c%0d rsp_status", c), 32'(rsp_status), 32'h0);
                end else begin
                    chk($sformatf("rr c%0d rsp_id", c), 32'(rsp_id), 32'h1);
                    chk($sformatf("rr c%0d rsp_result", c), 32'(rsp_result), 32'h0000);
                    chk($sformatf("rr c%0d rsp_status", c), 32'(rsp_status), 32'h1);
                end
            end else begin
                chk($sformatf("rr c%0d rsp_valid", c), 32'(rsp_valid), 32'h0);
            end
            if (c == 11) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            tick();
        end
        rsp_ready = 1'b0;

        // Back-pressure: response held 5 cycles with req0 still pending.
        req0_valid = 1'b1;
        req0_fs    = 4'b0011;
        req0_a     = 16'h00F0;
        req0_b     = 16'h0F00;
        #1;
        chk("bp T req0_ready", 32'(req0_ready), 32'h1);
        tick();
        chk("bp EXEC req0_ready", 32'(req0_ready), 32'h0);
        tick();
        for (int r = 0; r < 5; r++) begin
            chk($sformatf("bp r%0d rsp_valid", r), 32'(rsp_valid), 32'h1);
            chk($sformatf("bp r%0d rsp_result", r), 32'(rsp_result), 32'h0FF0);
            chk($sformatf("bp r%0d rsp_id", r), 32'(rsp_id), 32'h0);
            chk($sformatf("bp r%0d rsp_err", r), 32'(rsp_err), 32'h0);
            chk($sformatf("bp r%0d req0_ready", r), 32'(req0_ready), 32'h0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp accept rsp_valid", 32'(rsp_valid), 32'h1);
        chk("bp accept req0_ready", 32'(req0_ready), 32'h0);
        tick();
        rsp_ready = 1'b0;
        chk("bp after req0_ready", 32'(req0_ready), 32'h1);
        chk("bp after rsp_valid", 32'(rsp_valid), 32'h0);
        tick();

        // Reset pulsed mid-EXEC: outputs clear without waiting for a clock.
        req0_valid = 1'b0;
        #1;
        chk("rst EXEC fu_fs before", 32'(fu_fs), 32'h3);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst async");
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("rst post k%0d rsp_valid", k), 32'(rsp_valid), 32'h0);
        end
        // Last grant before reset was req0; only a reset pointer hands req0 the tie.
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("rst tie req0_ready", 32'(req0_ready), 32'h1);
        chk("rst tie req1_ready", 32'(req1_ready), 32'h0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
